// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and the byte-strobe helper
// used by the ahb_sram_slave block.
package ahb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Lane strobes for a naturally aligned access; illegal sizes give no lanes.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << off;
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// DEPTH x 32-bit storage: asynchronous read, synchronous per-lane write.
// Shares one captured index between read and write ports.
module ahb_sram_mem
  import ahb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states and ERROR response.
// Define AHB_SRAM_XN_GUARD_EN to reject opcode fetches (hprot[0]=0).
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [3:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int AW = $clog2(DEPTH);

  state_e            state, state_nxt;
  logic [3:0]        cnt_p0, cnt_nxt;
  logic              wr_p0;
  logic [AW-1:0]     idx_p0;
  logic [1:0]        off_p0;
  logic [2:0]        size_p0;
  logic              can_accept, accept, illegal, mem_we;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_bits;

  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept && hsel && htrans[1] && hready;

  always_comb begin
    illegal = 1'b0;
    if (hsize > 3'b010) illegal = 1'b1;
    if (hsize == 3'b001 && haddr[0]) illegal = 1'b1;
    if (hsize == 3'b010 && haddr[1:0] != 2'b00) illegal = 1'b1;
`ifdef AHB_SRAM_XN_GUARD_EN
    if (!hprot[0]) illegal = 1'b1;
`endif
  end

`ifdef AHB_SRAM_XN_GUARD_EN
  assign unused_bits = ^{hprot[3:1], htrans[0], haddr[31:AW+2]};
`else
  assign unused_bits = ^{hprot, htrans[0], haddr[31:AW+2]};
`endif

  // Address phase -> data phase boundary: control registers
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state  <= ST_IDLE;
      cnt_p0 <= '0;
      wr_p0  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt_p0 <= cnt_nxt;
      if (accept) wr_p0 <= hwrite;
    end
  end

  // Address phase -> data phase boundary: captured address/size
  always_ff @(posedge hclk) begin
    if (accept) begin
      idx_p0  <= haddr[AW+1:2];
      off_p0  <= haddr[1:0];
      size_p0 <= hsize;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p0;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (state == ST_ERR2) hresp = HRESP_ERROR;
        if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_nxt   = cnt_p0 - 4'd1;
        if (cnt_p0 == 4'd1) state_nxt = ST_DATA;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The write lands on the edge that closes DATA, so a following read sees it.
  assign mem_we = (state == ST_DATA) && wr_p0;
  assign mem_be = byte_en(size_p0, off_p0);

  ahb_sram_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (hclk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (idx_p0),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  assign hrdata = (state == ST_DATA && !wr_p0) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one zero-wait and one 3-wait instance
// share the address/data bus; expectations come from a small word model.
module tb_ahb_sram_slave;

  localparam int WS3 = 3;

  logic        hclk = 1'b0;
  logic        hreset, hsel, use3;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;

  logic        hsel0, hready0, hresp0;
  logic        hsel3, hready3, hresp3;
  logic [31:0] hrdata0, hrdata3;
  logic        rdy_cur, resp_cur;
  logic [31:0] rdata_cur;

  always #5 hclk = ~hclk;

  assign hsel0     = hsel && !use3;
  assign hsel3     = hsel && use3;
  assign rdy_cur   = use3 ? hready3 : hready0;
  assign resp_cur  = use3 ? hresp3  : hresp0;
  assign rdata_cur = use3 ? hrdata3 : hrdata0;

  ahb_sram_slave #(.DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hready(hready0), .hreadyout(hready0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_sram_slave #(.DEPTH(16), .WAIT_STATES(WS3)) u_dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hready(hready3), .hreadyout(hready3), .hresp(hresp3), .hrdata(hrdata3)
  );

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          low;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [int];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  bit          pending = 1'b0;
  int          low_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int mkey(input logic [31:0] a);
    return use3 ? 1000 + int'(a[5:2]) : int'(a[7:2]);
  endfunction

  // Data-phase monitor: sampled mid-cycle, pops one expectation per completed transfer.
  always @(negedge hclk) begin
    exp_t e;
    if (!mon_en || hreset) begin
      pending = 1'b0;
      low_cnt = 0;
    end else begin
      if (pending) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) begin
          pending = 1'b0;
        end else begin
          e = exp_q[0];
          if (!rdy_cur) begin
            low_cnt++;
            chk("resp_wait", 32'(resp_cur), 32'(e.err));
            if (low_cnt > 20) begin
              chk("wait_bound", 32'(low_cnt), 32'(e.low));
              void'(exp_q.pop_front());
              pending = 1'b0;
              low_cnt = 0;
            end
          end else begin
            chk("resp", 32'(resp_cur), 32'(e.err));
            chk("low_cycles", 32'(low_cnt), 32'(e.low));
            chk("rdata", rdata_cur, (e.rd && !e.err) ? e.data : 32'h0);
            void'(exp_q.pop_front());
            pending = 1'b0;
            low_cnt = 0;
          end
        end
      end
      if (hsel && htrans[1] && rdy_cur) pending = 1'b1;
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [3:0] prot, input logic [31:0] wdata,
                      input logic [1:0] tr = 2'b10, input bit use_exp = 1'b0,
                      input logic [31:0] exp_data = 32'h0);
    exp_t        e;
    logic        illegal, en;
    logic [31:0] w;
    int          k, n;
    illegal = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
`ifdef AHB_SRAM_XN_GUARD_EN
    if (!prot[0]) illegal = 1'b1;
`endif
    e.rd   = !wr;
    e.err  = illegal;
    e.low  = illegal ? 1 : (use3 ? WS3 : 0);
    e.data = 32'h0;
    if (!illegal) begin
      k = mkey(addr);
      if (wr) begin
        w = model.exists(k) ? model[k] : 32'h0;
        for (int i = 0; i < 4; i++) begin
          en = (size == 3'd2) || (size == 3'd1 && (i / 2) == int'(addr[1])) ||
               (size == 3'd0 && i == int'(addr[1:0]));
          if (en) w[8*i +: 8] = wdata[8*i +: 8];
        end
        model[k] = w;
      end else begin
        e.data = model.exists(k) ? model[k] : 32'h0;
      end
    end
    if (use_exp) e.data = exp_data;
    exp_q.push_back(e);
    hsel   = 1'b1;
    htrans = tr;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hprot  = prot;
    n = 0;
    @(negedge hclk);
    while (!rdy_cur && n < 50) begin
      n++;
      @(negedge hclk);
    end
    if (n >= 50) chk("drv_timeout", 32'(n), 32'd0);
    @(posedge hclk);
    #1;
    hwdata = wdata;
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pending) && n < 60) begin
      @(posedge hclk);
      #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_run(input int cnt);
    logic [31:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = 32'hB000_0000 | 32'($urandom_range(0, 63));
      xfer(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           $urandom(), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge hclk);
        #1;
      end
    end
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; use3 = 1'b0; htrans = 2'b00; haddr = '0;
    hwdata = '0; hwrite = 1'b0; hsize = 3'd0; hprot = 4'b0001;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_rdy0", 32'(hready0), 32'd1);
    chk("rst_resp0", 32'(hresp0), 32'd0);
    chk("rst_rdata0", hrdata0, 32'h0);
    chk("rst_rdy3", 32'(hready3), 32'd1);
    chk("rst_resp3", 32'(hresp3), 32'd0);
    chk("rst_rdata3", hrdata3, 32'h0);
    hreset = 1'b0;
    mon_en = 1'b1;
    @(posedge hclk);
    #1;

    // Zero-wait instance: directed cases
    xfer(1, 32'hB000_0010, 3'd2, 4'b0001, 32'hDEAD_BEEF);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0, 2'b10, 1, 32'hDEAD_BEEF);
    xfer(1, 32'hB000_0010, 3'd2, 4'b0001, 32'h1122_3344);
    xfer(1, 32'hB000_0013, 3'd0, 4'b0001, 32'hAA5A_5A5A);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0, 2'b10, 1, 32'hAA22_3344);
    xfer(1, 32'hB000_0012, 3'd1, 4'b0001, 32'h5566_9999);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0, 2'b10, 1, 32'h5566_3344);
    xfer(0, 32'hB000_0002, 3'd2, 4'b0001, 32'h0);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0, 2'b10, 1, 32'h5566_3344);
    xfer(0, 32'hB000_0010, 3'd3, 4'b0001, 32'h0);
    xfer(1, 32'hB000_0011, 3'd1, 4'b0001, 32'hFFFF_FFFF);
    xfer(0, 32'hB000_1010, 3'd2, 4'b0001, 32'h0, 2'b11, 1, 32'h5566_3344);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0000, 32'h0);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0);
    drain();

    // BUSY with hsel must not open a data phase
    hsel = 1'b1; htrans = 2'b01; haddr = 32'hB000_0010; hwrite = 1'b0; hsize = 3'd2;
    @(negedge hclk);
    chk("busy_rdy", 32'(rdy_cur), 32'd1);
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("busy_no_dphase_rdy", 32'(rdy_cur), 32'd1);
    chk("busy_no_dphase_rdata", rdata_cur, 32'h0);
    @(posedge hclk);
    #1;

    for (int i = 0; i < 16; i++) xfer(1, 32'hB000_0000 + 32'(4 * i), 3'd2, 4'b0001, $urandom());
    rand_run(60);
    drain();

    // Three-wait-state instance
    use3 = 1'b1;
    @(posedge hclk);
    #1;
    for (int i = 0; i < 16; i++) xfer(1, 32'hB000_0000 + 32'(4 * i), 3'd2, 4'b0001, $urandom());
    xfer(1, 32'hB000_0010, 3'd2, 4'b0001, 32'hCAFE_F00D);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0, 2'b10, 1, 32'hCAFE_F00D);
    xfer(0, 32'hB000_0002, 3'd2, 4'b0001, 32'h0);
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0, 2'b10, 1, 32'hCAFE_F00D);
    rand_run(20);
    drain();

    // Reset in the middle of a wait sequence
    mon_en = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'hB000_0010; hwrite = 1'b1; hsize = 3'd2;
    hprot = 4'b0001;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0BAD_0BAD;
    @(posedge hclk);
    #1;
    chk("mid_wait_low", 32'(hready3), 32'd0);
    hreset = 1'b1;
    #1;
    chk("rst_async_rdy", 32'(hready3), 32'd1);
    chk("rst_async_resp", 32'(hresp3), 32'd0);
    chk("rst_async_rdata", hrdata3, 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(posedge hclk);
    #1;
    mon_en = 1'b1;
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0);
    drain();
    use3 = 1'b0;
    @(posedge hclk);
    #1;
    xfer(0, 32'hB000_0010, 3'd2, 4'b0001, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
